// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - processor/debug arbiter for a single-port data memory
// Round-robin in IDLE; LOCK gives the debug port a bounded burst of priority grants.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_q,
  input  logic              d_req,
  input  logic              d_wren,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  state_t      r_state, w_state_nxt;
  logic        r_lg, w_lg_nxt;
  logic [7:0]  r_lcnt, w_lcnt_nxt;
  logic        r_p_rvalid, r_d_rvalid;
  logic        w_p_gnt, w_d_gnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lg       <= 1'b1;
      r_lcnt     <= 8'd0;
      r_p_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lg       <= w_lg_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_p_rvalid <= w_p_gnt & ~p_wren;
      r_d_rvalid <= w_d_gnt & ~d_wren;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lg_nxt    = r_lg;
    w_lcnt_nxt  = r_lcnt;
    if (w_p_gnt) begin
      w_lg_nxt = 1'b0;
    end else if (w_d_gnt) begin
      w_lg_nxt = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        // A one-grant burst limit is already exhausted by the entry grant.
        if (w_d_gnt && d_lock && (LMAX > 8'd1)) begin
          w_state_nxt = S_LOCK;
          w_lcnt_nxt  = 8'd1;
        end
      end
      S_LOCK: begin
        if (!d_lock) begin
          w_state_nxt = S_IDLE;
          w_lcnt_nxt  = 8'd0;
        end else if (w_d_gnt) begin
          if ((r_lcnt + 8'd1) >= LMAX) begin
            w_state_nxt = S_IDLE;
            w_lcnt_nxt  = 8'd0;
            w_lg_nxt    = 1'b1;
          end else begin
            w_lcnt_nxt = r_lcnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_lcnt_nxt  = 8'd0;
      end
    endcase
  end

  always_comb begin
    w_p_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!reset) begin
      if (r_state == S_LOCK) begin
        w_d_gnt = d_req;
        w_p_gnt = p_req & ~d_req;
      end else if (p_req && d_req) begin
        w_p_gnt = r_lg;
        w_d_gnt = ~r_lg;
      end else begin
        w_p_gnt = p_req;
        w_d_gnt = d_req;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (w_p_gnt) begin
      mem_addr = p_addr;
      mem_data = p_data;
      mem_wren = p_wren;
    end else if (w_d_gnt) begin
      mem_addr = d_addr;
      mem_data = d_data;
      mem_wren = d_wren;
    end
  end

  assign p_gnt    = w_p_gnt;
  assign d_gnt    = w_d_gnt;
  assign p_rvalid = r_p_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign p_q      = mem_q;
  assign d_q      = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter
// Reference model tracks last winner, lock flag and burst length; grants are checked every cycle.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LMAX = 4;

  logic          clock, reset;
  logic          p_req, p_wren, d_req, d_wren, d_lock;
  logic [AW-1:0] p_addr, d_addr;
  logic [DW-1:0] p_data, d_data, mem_q;
  logic          p_gnt, p_rvalid, d_gnt, d_rvalid, mem_wren;
  logic [DW-1:0] p_q, d_q, mem_data;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad = 0;

  // reference model state
  bit m_lg, m_locked, m_prv, m_drv;
  int m_burst;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_q(p_q),
    .d_req(d_req), .d_wren(d_wren), .d_lock(d_lock), .d_addr(d_addr), .d_data(d_data),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_q(d_q),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lg = 1'b1; m_locked = 1'b0; m_burst = 0; m_prv = 1'b0; m_drv = 1'b0;
  endtask

  // Entered just after a falling edge with inputs applied; returns 1=P, 2=D, 0=none.
  task automatic cycle(input logic [DW-1:0] q, output int g);
    bit eg_p, eg_d;
    mem_q = q;
    #1;
    if (m_locked) begin
      eg_d = d_req;
      eg_p = p_req && !d_req;
    end else if (p_req && d_req) begin
      eg_d = (m_lg == 1'b0);
      eg_p = !eg_d;
    end else begin
      eg_p = p_req;
      eg_d = d_req;
    end
    chk("p_gnt", p_gnt, eg_p);
    chk("d_gnt", d_gnt, eg_d);
    chk("mem_addr", mem_addr, eg_p ? p_addr : (eg_d ? d_addr : '0));
    chk("mem_data", mem_data, eg_p ? p_data : (eg_d ? d_data : '0));
    chk("mem_wren", mem_wren, eg_p ? p_wren : (eg_d ? d_wren : 1'b0));
    chk("p_rvalid", p_rvalid, m_prv);
    chk("d_rvalid", d_rvalid, m_drv);
    if (m_prv) chk("p_q", p_q, q);
    if (m_drv) chk("d_q", d_q, q);
    g = p_gnt ? 1 : (d_gnt ? 2 : 0);
    m_prv = eg_p && !p_wren;
    m_drv = eg_d && !d_wren;
    if (eg_p) m_lg = 1'b0;
    if (eg_d) m_lg = 1'b1;
    if (!m_locked) begin
      if (eg_d && d_lock && LMAX > 1) begin
        m_locked = 1'b1;
        m_burst = 1;
      end
    end else if (!d_lock) begin
      m_locked = 1'b0;
    end else if (eg_d) begin
      m_burst++;
      if (m_burst == LMAX) m_locked = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic run_seq(input string tag, input string pat);
    int g;
    int e;
    for (int i = 0; i < pat.len(); i++) begin
      cycle($urandom, g);
      e = (pat.getc(i) == "P") ? 1 : ((pat.getc(i) == "D") ? 2 : 0);
      chk(tag, g, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_p_gnt", p_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_mem_wren", mem_wren, 1'b0);
    @(negedge clock);
    #1;
    chk("rst_p_rvalid", p_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int g;
    reset = 1'b1;
    p_req = 1'b1; p_wren = 1'b1; p_addr = '0; p_data = '0;
    d_req = 1'b1; d_wren = 1'b1; d_lock = 1'b0; d_addr = '0; d_data = '0;
    mem_q = '0;
    @(negedge clock);
    do_reset();

    // single processor read
    p_req = 1'b1; p_wren = 1'b0; p_addr = 12'h005; p_data = 32'h0;
    d_req = 1'b0; d_wren = 1'b0;
    cycle($urandom, g);
    chk("p_only_gnt", g, 1);
    p_req = 1'b0;
    cycle(32'hDEADBEEF, g);
    chk("p_only_idle", g, 0);

    // contention round robin
    do_reset();
    p_req = 1'b1; d_req = 1'b1; p_wren = 1'b0; d_wren = 1'b0; d_lock = 1'b0;
    p_addr = 12'h011; d_addr = 12'h022;
    run_seq("rr_seq", "PDPDPD");

    // lock burst bounded by LOCK_MAX, then alternation
    do_reset();
    d_lock = 1'b1;
    run_seq("lock_seq", "PDDDDP");
    d_lock = 1'b0;
    run_seq("post_lock_seq", "DPD");

    // early unlock
    do_reset();
    d_lock = 1'b1;
    run_seq("early_seq", "PDD");
    d_lock = 1'b0;
    run_seq("early_exit_seq", "DPDP");

    // debug write
    do_reset();
    p_req = 1'b0;
    d_req = 1'b1; d_wren = 1'b1; d_addr = 12'h018; d_data = 32'h12345678;
    cycle($urandom, g);
    chk("d_write_gnt", g, 2);
    d_req = 1'b0; d_wren = 1'b0;
    cycle($urandom, g);
    chk("d_write_idle", g, 0);

    // reset in the middle of a locked read burst
    do_reset();
    p_req = 1'b1; d_req = 1'b1; p_wren = 1'b0; d_wren = 1'b0; d_lock = 1'b1;
    run_seq("mid_rst_pre", "PD");
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_p_gnt", p_gnt, 1'b0);
    chk("mid_rst_d_gnt", d_gnt, 1'b0);
    chk("mid_rst_wren", mem_wren, 1'b0);
    chk("mid_rst_d_rvalid", d_rvalid, 1'b0);
    @(negedge clock);
    #1;
    chk("mid_rst_p_rvalid2", p_rvalid, 1'b0);
    chk("mid_rst_d_rvalid2", d_rvalid, 1'b0);
    reset = 1'b0;
    model_reset();
    d_lock = 1'b0;
    run_seq("mid_rst_post", "PD");

    // randomized traffic; requesters hold their request until granted
    do_reset();
    p_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom, g);
      if (!p_req || g == 1) begin
        p_req  = ($urandom_range(9) < 7);
        p_wren = ($urandom_range(3) == 0);
        p_addr = AW'($urandom);
        p_data = $urandom;
      end
      if (!d_req || g == 2) begin
        d_req  = ($urandom_range(9) < 6);
        d_wren = ($urandom_range(3) == 0);
        d_addr = AW'($urandom);
        d_data = $urandom;
      end
      if ($urandom_range(7) == 0) d_lock = ~d_lock;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, data-memory word address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter LOCK_MAX, default 16, maximum consecutive debug grants under lock (range 1..255).
REQ-004 clock  input  1  single clock for all state; all registers update on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 p_req, p_wren  input  1 each  processor request and write-enable.
REQ-007 p_addr  input  ADDR_W; p_data  input  DATA_W  processor address and write data.
REQ-008 p_gnt  output  1  processor access accepted this cycle (combinational from current state and requests).
REQ-009 p_rvalid  output  1; p_q  output  DATA_W  processor read response.
REQ-010 d_req, d_wren, d_lock  input  1 each  debug/loader request, write-enable, burst-lock.
REQ-011 d_addr  input  ADDR_W; d_data  input  DATA_W  debug address and write data.
REQ-012 d_gnt  output  1; d_rvalid  output  1; d_q  output  DATA_W  debug grant and read response.
REQ-013 mem_addr  output  ADDR_W; mem_data  output  DATA_W; mem_wren  output  1  single-port memory command.
REQ-014 mem_q  input  DATA_W  memory read data, valid exactly one cycle after the address cycle.

Function
REQ-015 At most one of p_gnt, d_gnt SHALL be high in any cycle; a grant SHALL be raised only when the matching req is high.
REQ-016 The memory command SHALL be a combinational mux of the granted requester's addr/data/wren; with no grant, mem_wren = 0 and mem_addr/mem_data = 0.
REQ-017 States: IDLE, LOCK. In IDLE, arbitration SHALL be round-robin using a 1-bit last-grant pointer lg (0 = processor, 1 = debug).
REQ-018 IDLE, single requester: that requester is granted. Both requesting: the requester not equal to lg is granted.
REQ-019 lg SHALL update to the granted requester on every cycle with a grant; it is unchanged on idle cycles.
REQ-020 IDLE -> LOCK when d_gnt and d_lock are both high; lock counter lcnt loads 1.
REQ-021 In LOCK, the debug requester SHALL have absolute priority: d_gnt = d_req, and p_gnt = p_req and not d_req.
REQ-022 In LOCK, lcnt SHALL increment on each debug grant; LOCK -> IDLE when d_lock deasserts, or when a debug grant occurs with lcnt = LOCK_MAX; on that forced exit lg = 1, so a pending processor request wins the next cycle.
REQ-023 Read response: on a granted cycle with wren = 0, the matching rvalid SHALL be high on the next cycle, and the matching q SHALL equal mem_q; otherwise rvalid = 0.
REQ-024 p_q and d_q SHALL both drive mem_q continuously; only rvalid qualifies the data.
REQ-025 Write cycles SHALL produce no rvalid; a write is complete on its grant cycle.
REQ-026 Requesters SHALL hold req, addr, data and wren stable until granted; the arbiter does not buffer requests.
REQ-027 Back-to-back grants to either requester SHALL be allowed every cycle: throughput is one access per cycle, read latency is 1 cycle.
REQ-028 A read granted in the same cycle that reset asserts SHALL produce no rvalid.

Reset
REQ-029 On reset: state = IDLE, lg = 1 (processor wins the first contended cycle), lcnt = 0, and both rvalid flags = 0.
REQ-030 During reset, p_gnt, d_gnt and mem_wren SHALL be 0 regardless of the request inputs.

Verification
REQ-031 Processor only: p_req=1, p_wren=0, p_addr=0x005 for one cycle, mem_q=0xDEADBEEF next cycle -> p_gnt=1, mem_addr=0x005, next cycle p_rvalid=1, p_q=0xDEADBEEF, d_rvalid=0.
REQ-032 Contention: both requesters reading continuously for 6 cycles after reset -> grants alternate P,D,P,D,P,D, and each rvalid appears one cycle after its own grant.
REQ-033 Lock burst: d_lock=1, with d_req and p_req high continuously, LOCK_MAX=4 -> 4 consecutive d_gnt, then p_gnt next cycle, then alternation resumes.
REQ-034 Early unlock: d_lock drops after 2 debug grants with p_req pending -> next cycle p_gnt=1, state IDLE.
REQ-035 Write: d_req=1, d_wren=1, d_addr=0x018, d_data=0x12345678 -> mem_wren=1, mem_addr=0x018, mem_data=0x12345678 for one cycle, and no d_rvalid.
REQ-036 Mid-operation reset: assert reset during LOCK with a read granted -> asynchronously all grants=0, mem_wren=0, no rvalid, state IDLE with lg=1 after release.
